integrated_circuit_core: RTL and testbench
==========================================

INTEGRATED_CIRCUIT_CORE -- requirements
Module: integrated_circuit

Interface
REQ-001 SHALL have: Ref_Clk  input  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: adjust  input  1  one-cycle-or-longer pulse starting a frequency measurement.
REQ-004 SHALL have: inFreq  input  1  asynchronous reference square wave to be multiplied.
REQ-005 SHALL have: n  input  3  multiplication exponent; output tick rate = inFreq x 2^n.
REQ-006 SHALL have: start_acc  input  1  level request to start the e^x computation.
REQ-007 SHALL have: x  input  16  unsigned Q0.16 argument, value x/65536 in [0,1).
REQ-008 SHALL have: done_multiplier  output  1  high while the multiplier is locked.
REQ-009 SHALL have: done_expo  output  1  high while the e^x result is valid.
REQ-010 SHALL have: intpart  output  2  integer part of e^x (Q2.16 result bits 17:16).
REQ-011 SHALL have: fracpart  output  16  fraction of e^x (result bits 15:0).

Function -- frequency multiplier
REQ-012 SHALL synchronize inFreq through two flops; a rising edge is detected on the synchronized signal.
REQ-013 SHALL use FSM M_IDLE -> M_WAIT (adjust sampled 1) -> M_COUNT (first rising edge) -> M_LOCK (next rising edge).
REQ-014 SHALL, in M_COUNT, count Ref_Clk cycles between consecutive rising edges in a 16-bit counter saturating at 0xFFFF.
REQ-015 SHALL, on entering M_LOCK, register period = count and div = max(period >> n, 1); n is sampled at that moment.
REQ-016 SHALL, in M_LOCK, generate a one-cycle tick every div Ref_Clk cycles (counter 0..div-1, tick on wrap).
REQ-017 SHALL drive done_multiplier = 1 only in M_LOCK.
REQ-018 SHALL restart measurement when adjust is 1 in any state (go to M_WAIT, done_multiplier = 0 next cycle).

Function -- e^x accelerator
REQ-019 SHALL use FSM A_IDLE -> A_RUN -> A_DONE -> A_IDLE.
REQ-020 SHALL leave A_IDLE only when start_acc = 1 and done_multiplier = 1; then latch x, term = 0x10000, sum = 0x10000, k = 1, done_expo = 0.
REQ-021 SHALL, in A_RUN, perform one iteration per tick only: t = (term * x) >> 16; term = (t * R[k]) >> 16; sum = sum + term; k = k + 1; all truncating, term/sum 18-bit unsigned.
REQ-022 SHALL use constants R[1..7] = 0xFFFF, 0x8000, 0x5555, 0x4000, 0x3333, 0x2AAB, 0x2492 (65536/k rounded; k=1 saturated).
REQ-023 SHALL, after the k = 7 iteration, enter A_DONE and update {intpart, fracpart} = sum[17:0].
REQ-024 SHALL hold done_expo = 1 in A_DONE until start_acc = 0, then return to A_IDLE with done_expo = 0; outputs keep the last result.
REQ-025 SHALL ignore x changes during A_RUN.
REQ-026 SHALL abort A_RUN to A_IDLE (outputs unchanged, done_expo = 0) if done_multiplier falls.
REQ-027 SHALL complete in exactly 7 ticks after the start cycle (7*div Ref_Clk cycles worst-case alignment plus 1).

Reset
REQ-028 SHALL, while rst = 1 at a clock edge, enter M_IDLE and A_IDLE and clear done_multiplier, done_expo, intpart, fracpart, all counters and registers to 0.
REQ-029 SHALL ignore adjust and start_acc during reset; rst mid-measurement or mid-computation aborts with the same reset values.

Verification
REQ-030 inFreq period = 15 Ref_Clk cycles, n = 3, adjust pulse -> done_multiplier = 1 after second inFreq rising edge, div = 1, tick every cycle.
REQ-031 Locked, x = 0x0000, start_acc = 1 -> done_expo = 1 after 7 ticks, intpart = 1, fracpart = 0x0000.
REQ-032 Locked, x = 0x8000 -> intpart = 1, fracpart equals bit-exact model of REQ-021 (within 8 LSB of 0xA612).
REQ-033 Locked, x = 0xFFFF -> intpart = 2, fracpart bit-exact to model (within 8 LSB of 0xB7E1).
REQ-034 start_acc = 1 before adjust (unlocked) -> done_expo stays 0; adjust during A_RUN -> abort, done_expo = 0.
REQ-035 rst = 1 during A_RUN -> next cycle all outputs 0; period 40 cycles, n = 7 -> div = 1 (clamped).

Source files
------------

// File: rtl/integrated_circuit_core_if.sv
// Control/status bundle of the frequency multiplier and e^x accelerator.
// The master drives the measurement and computation requests. The slave
// (the core) returns the lock flag, the valid flag and the Q2.16 result.
interface integrated_circuit_core_if;
    logic        adjust;
    logic        inFreq;
    logic [2:0]  n;
    logic        start_acc;
    logic [15:0] x;
    logic        done_multiplier;
    logic        done_expo;
    logic [1:0]  intpart;
    logic [15:0] fracpart;

    modport master (
        output adjust,
        output inFreq,
        output n,
        output start_acc,
        output x,
        input  done_multiplier,
        input  done_expo,
        input  intpart,
        input  fracpart
    );

    modport slave (
        input  adjust,
        input  inFreq,
        input  n,
        input  start_acc,
        input  x,
        output done_multiplier,
        output done_expo,
        output intpart,
        output fracpart
    );
endinterface

// File: rtl/integrated_circuit_core.sv
// Frequency multiplier plus a tick-paced e^x series accelerator.
//
// The multiplier measures the period of inFreq in Ref_Clk cycles. It then
// emits a one-cycle tick every max(period >> n, 1) cycles, so the tick rate
// is inFreq x 2^n. The accelerator evaluates the truncated Taylor series
// e^x = 1 + x + x^2/2! + ... + x^7/7!. It computes one term per tick, and
// each term is built from the previous one as term * x * (1/k).
module integrated_circuit_core (
    input  logic                          Ref_Clk,
    input  logic                          rst,
    integrated_circuit_core_if.slave      bus
);

    typedef enum logic [1:0] {
        M_IDLE  = 2'd0,
        M_WAIT  = 2'd1,
        M_COUNT = 2'd2,
        M_LOCK  = 2'd3
    } m_state_t;

    typedef enum logic [1:0] {
        A_IDLE = 2'd0,
        A_RUN  = 2'd1,
        A_DONE = 2'd2
    } a_state_t;

    // Q0.16 reciprocal of k for the series recurrence. The k = 1 entry
    // saturates at 0xFFFF because 1.0 does not fit in Q0.16.
    function automatic logic [15:0] recip(input logic [2:0] k);
        case (k)
            3'd1:    recip = 16'hFFFF;
            3'd2:    recip = 16'h8000;
            3'd3:    recip = 16'h5555;
            3'd4:    recip = 16'h4000;
            3'd5:    recip = 16'h3333;
            3'd6:    recip = 16'h2AAB;
            3'd7:    recip = 16'h2492;
            default: recip = 16'h0000;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Frequency multiplier state
    // ------------------------------------------------------------------
    m_state_t    m_state_q, m_state_d;
    logic        sync1_q, sync1_d;
    logic        sync2_q, sync2_d;
    logic        prev_q, prev_d;
    logic [15:0] count_q, count_d;
    logic [15:0] period_q, period_d;
    logic [15:0] div_q, div_d;
    logic [15:0] div_cnt_q, div_cnt_d;

    logic        in_rise;
    logic        tick;
    logic        locked;
    logic [15:0] shifted;

    // ------------------------------------------------------------------
    // Accelerator state
    // ------------------------------------------------------------------
    a_state_t    a_state_q, a_state_d;
    logic [15:0] x_q, x_d;
    logic [17:0] term_q, term_d;
    logic [17:0] sum_q, sum_d;
    logic [2:0]  k_q, k_d;
    logic [17:0] result_q, result_d;

    logic [33:0] prod_tx;
    logic [17:0] t_val;
    logic [33:0] prod_tr;
    logic [17:0] term_next;
    logic [17:0] sum_next;

    // Edge detect on the synchronized reference, plus tick and lock decode.
    always_comb begin
        in_rise = sync2_q & ~prev_q;
        locked  = (m_state_q == M_LOCK);
        tick    = locked && (div_cnt_q == (div_q - 16'd1));
        shifted = count_q >> bus.n;
    end

    // Multiplier next state: measure one inFreq period, then divide it down.
    always_comb begin
        // NOTE: every signal gets its hold value first so that no path through
        // the case statement leaves it unassigned and infers a latch.
        m_state_d = m_state_q;
        sync1_d   = bus.inFreq;
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        count_d   = count_q;
        period_d  = period_q;
        div_d     = div_q;
        div_cnt_d = div_cnt_q;

        if (bus.adjust) begin
            // A new measurement request overrides whatever was in progress.
            m_state_d = M_WAIT;
            count_d   = '0;
            div_cnt_d = '0;
        end else begin
            case (m_state_q)
                M_IDLE: begin
                end
                M_WAIT: begin
                    if (in_rise) begin
                        m_state_d = M_COUNT;
                        count_d   = 16'd1;
                    end
                end
                M_COUNT: begin
                    if (in_rise) begin
                        m_state_d = M_LOCK;
                        period_d  = count_q;
                        div_d     = (shifted == 16'd0) ? 16'd1 : shifted;
                        div_cnt_d = '0;
                    end else if (count_q != 16'hFFFF) begin
                        count_d = count_q + 16'd1;
                    end
                end
                M_LOCK: begin
                    div_cnt_d = tick ? 16'd0 : (div_cnt_q + 16'd1);
                end
                default: begin
                    m_state_d = M_IDLE;
                end
            endcase
        end
    end

    // One series step: t = term*x >> 16, term' = t*R[k] >> 16, sum' = sum + term'.
    always_comb begin
        prod_tx   = 34'(term_q) * 34'(x_q);
        t_val     = prod_tx[33:16];
        prod_tr   = 34'(t_val) * 34'(recip(k_q));
        term_next = prod_tr[33:16];
        sum_next  = sum_q + term_next;
    end

    // Accelerator next state: start when locked, step on ticks, hold the result.
    always_comb begin
        a_state_d = a_state_q;
        x_d       = x_q;
        term_d    = term_q;
        sum_d     = sum_q;
        k_d       = k_q;
        result_d  = result_q;

        case (a_state_q)
            A_IDLE: begin
                if (bus.start_acc && locked) begin
                    a_state_d = A_RUN;
                    x_d       = bus.x;
                    term_d    = 18'h10000;
                    sum_d     = 18'h10000;
                    k_d       = 3'd1;
                end
            end
            A_RUN: begin
                if (!locked) begin
                    a_state_d = A_IDLE;
                end else if (tick) begin
                    term_d = term_next;
                    sum_d  = sum_next;
                    k_d    = k_q + 3'd1;
                    if (k_q == 3'd7) begin
                        a_state_d = A_DONE;
                        result_d  = sum_next;
                    end
                end
            end
            A_DONE: begin
                if (!bus.start_acc) begin
                    a_state_d = A_IDLE;
                end
            end
            default: begin
                a_state_d = A_IDLE;
            end
        endcase
    end

    // Multiplier registers with synchronous reset.
    always_ff @(posedge Ref_Clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // which matters for the sync1 -> sync2 -> prev shift chain.
        if (rst) begin
            m_state_q <= M_IDLE;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            prev_q    <= 1'b0;
            count_q   <= '0;
            period_q  <= '0;
            div_q     <= '0;
            div_cnt_q <= '0;
        end else begin
            m_state_q <= m_state_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            count_q   <= count_d;
            period_q  <= period_d;
            div_q     <= div_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    // Accelerator registers with synchronous reset.
    always_ff @(posedge Ref_Clk) begin
        if (rst) begin
            a_state_q <= A_IDLE;
            x_q       <= '0;
            term_q    <= '0;
            sum_q     <= '0;
            k_q       <= '0;
            result_q  <= '0;
        end else begin
            a_state_q <= a_state_d;
            x_q       <= x_d;
            term_q    <= term_d;
            sum_q     <= sum_d;
            k_q       <= k_d;
            result_q  <= result_d;
        end
    end

    // Status and result outputs decoded from registered state.
    always_comb begin
        bus.done_multiplier = locked;
        bus.done_expo       = (a_state_q == A_DONE);
        bus.intpart         = result_q[17:16];
        bus.fracpart        = result_q[15:0];
    end

endmodule

// File: tb/tb_integrated_circuit_core.sv
// Directed bench for integrated_circuit_core with a result scoreboard.
module tb_integrated_circuit_core;

    logic Ref_Clk = 1'b0;
    logic rst;

    integrated_circuit_core_if bus();

    integrated_circuit_core dut (
        .Ref_Clk (Ref_Clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial forever #5 Ref_Clk = ~Ref_Clk;

    int checks = 0;
    int errors = 0;

    // Square-wave reference generator, period in Ref_Clk cycles.
    int in_period = 15;
    bit in_en     = 1'b0;

    typedef struct {
        logic [15:0] xv;
        logic [17:0] res;
    } exp_t;

    exp_t sb[$];
    logic [17:0] last_res;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned recip_k(input int k);
        case (k)
            1: return 64'hFFFF;
            2: return 64'h8000;
            3: return 64'h5555;
            4: return 64'h4000;
            5: return 64'h3333;
            6: return 64'h2AAB;
            7: return 64'h2492;
            default: return 64'h0;
        endcase
    endfunction

    // Reference: truncated series, 18-bit unsigned term and sum.
    function automatic logic [17:0] exp_model(input logic [15:0] xv);
        longint unsigned term;
        longint unsigned sum;
        longint unsigned t;
        logic [17:0] r;
        term = 65536;
        sum  = 65536;
        for (int k = 1; k <= 7; k++) begin
            t    = (term * longint'(xv)) / 65536;
            term = ((t * recip_k(k)) / 65536) % 262144;
            sum  = (sum + term) % 262144;
        end
        r = sum[17:0];
        return r;
    endfunction

    initial begin
        bus.inFreq = 1'b0;
        forever begin
            if (in_en) begin
                bus.inFreq = 1'b1;
                repeat (in_period / 2) @(negedge Ref_Clk);
                bus.inFreq = 1'b0;
                repeat (in_period - in_period / 2) @(negedge Ref_Clk);
            end else begin
                bus.inFreq = 1'b0;
                @(negedge Ref_Clk);
            end
        end
    end

    task automatic pulse_adjust();
        bus.adjust = 1'b1;
        @(negedge Ref_Clk);
        bus.adjust = 1'b0;
    endtask

    task automatic wait_lock(input string tag);
        int cyc = 0;
        while (!bus.done_multiplier && cyc < 2000) begin
            @(negedge Ref_Clk);
            cyc++;
        end
        check(tag, 32'(bus.done_multiplier), 32'd1);
    endtask

    // Start one computation, scramble x mid-run, and check the result and latency.
    task automatic run_expo(input string tag, input logic [15:0] xv,
                            input int lat_min, input int lat_max);
        exp_t e;
        int   lat;
        e.xv  = xv;
        e.res = exp_model(xv);
        sb.push_back(e);
        bus.x         = xv;
        bus.start_acc = 1'b1;
        @(negedge Ref_Clk);
        lat    = 1;
        bus.x  = ~xv ^ 16'h1234;
        while (!bus.done_expo && lat < 400) begin
            @(negedge Ref_Clk);
            lat++;
        end
        check({tag, "_done"}, 32'(bus.done_expo), 32'd1);
        if (lat_min == lat_max)
            check({tag, "_latency"}, 32'(lat), 32'(lat_min));
        else
            check({tag, "_latency_range"}, (lat >= lat_min && lat <= lat_max) ? 32'd1 : 32'd0, 32'd1);
        check({tag, "_sb_nonempty"}, (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_intpart"}, 32'(bus.intpart), 32'(e.res[17:16]));
            check({tag, "_fracpart"}, 32'(bus.fracpart), 32'(e.res[15:0]));
            last_res = e.res;
        end
        bus.start_acc = 1'b0;
        @(negedge Ref_Clk);
        check({tag, "_release"}, 32'(bus.done_expo), 32'd0);
        check({tag, "_hold"}, 32'({bus.intpart, bus.fracpart}), 32'(last_res));
    endtask

    initial begin
        rst           = 1'b1;
        bus.adjust    = 1'b0;
        bus.n         = 3'd0;
        bus.start_acc = 1'b0;
        bus.x         = 16'h0000;
        last_res      = '0;
        repeat (2) @(negedge Ref_Clk);
        // Requests asserted during reset must be ignored.
        bus.adjust    = 1'b1;
        bus.start_acc = 1'b1;
        repeat (3) @(negedge Ref_Clk);
        check("reset_done_multiplier", 32'(bus.done_multiplier), 32'd0);
        check("reset_done_expo", 32'(bus.done_expo), 32'd0);
        check("reset_intpart", 32'(bus.intpart), 32'd0);
        check("reset_fracpart", 32'(bus.fracpart), 32'd0);
        bus.adjust = 1'b0;
        rst        = 1'b0;

        // Start requested while unlocked: nothing happens.
        in_en = 1'b1;
        repeat (40) @(negedge Ref_Clk);
        check("unlocked_done_multiplier", 32'(bus.done_multiplier), 32'd0);
        check("unlocked_done_expo", 32'(bus.done_expo), 32'd0);
        bus.start_acc = 1'b0;

        // Period 15, n = 3: div = 1, one tick per cycle.
        bus.n = 3'd3;
        pulse_adjust();
        check("adjust_clears_lock", 32'(bus.done_multiplier), 32'd0);
        wait_lock("lock_p15_n3");

        run_expo("x0000", 16'h0000, 8, 8);
        run_expo("x8000", 16'h8000, 8, 8);
        run_expo("xFFFF", 16'hFFFF, 8, 8);
        run_expo("xrand0", 16'($urandom), 8, 8);
        run_expo("xrand1", 16'($urandom), 8, 8);

        // Abort by adjust during A_RUN.
        bus.x         = 16'h3000;
        bus.start_acc = 1'b1;
        repeat (3) @(negedge Ref_Clk);
        bus.adjust    = 1'b1;
        bus.start_acc = 1'b0;
        @(negedge Ref_Clk);
        bus.adjust = 1'b0;
        check("abort_lock_dropped", 32'(bus.done_multiplier), 32'd0);
        @(negedge Ref_Clk);
        check("abort_done_expo", 32'(bus.done_expo), 32'd0);
        check("abort_outputs_held", 32'({bus.intpart, bus.fracpart}), 32'(last_res));
        wait_lock("relock_after_abort");

        // Reset during A_RUN clears every output on the next cycle.
        bus.x         = 16'hC000;
        bus.start_acc = 1'b1;
        repeat (3) @(negedge Ref_Clk);
        rst = 1'b1;
        @(negedge Ref_Clk);
        check("midrun_reset_done_multiplier", 32'(bus.done_multiplier), 32'd0);
        check("midrun_reset_done_expo", 32'(bus.done_expo), 32'd0);
        check("midrun_reset_result", 32'({bus.intpart, bus.fracpart}), 32'd0);
        rst           = 1'b0;
        bus.start_acc = 1'b0;

        // Period 15, n = 0: div = 15; latency depends on tick phase.
        bus.n = 3'd0;
        pulse_adjust();
        wait_lock("lock_p15_n0");
        run_expo("div15", 16'h6000, 6 * 15 + 2, 7 * 15 + 1);

        // Period 40, n = 7: 40 >> 7 = 0, clamped to div = 1.
        in_period = 40;
        repeat (50) @(negedge Ref_Clk);
        bus.n = 3'd7;
        pulse_adjust();
        wait_lock("lock_p40_n7");
        run_expo("clamp_div1", 16'h4000, 8, 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
